// File: rtl/csa_32.sv
// csa_32: registered 32-bit carry-select adder; ripple blocks of BLOCK_WIDTH bits, upper blocks precompute both carries
module csa_32 #(
    parameter int BLOCK_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    localparam int NB = 32 / BLOCK_WIDTH;
    logic [NB:0] c;
    logic [31:0] sum, s_d, s_q;
    logic        cout_d, cout_q;
    assign c[0] = cin;
    genvar i, j;
    generate
        if (32 % BLOCK_WIDTH != 0) begin : g_bad
            $error("csa_32: BLOCK_WIDTH must divide 32");
        end
        for (i = 0; i < NB; i++) begin : g_blk
            logic [BLOCK_WIDTH-1:0] p, g;
            assign p = a[i*BLOCK_WIDTH +: BLOCK_WIDTH] ^ b[i*BLOCK_WIDTH +: BLOCK_WIDTH];
            assign g = a[i*BLOCK_WIDTH +: BLOCK_WIDTH] & b[i*BLOCK_WIDTH +: BLOCK_WIDTH];
            if (i == 0) begin : g_lo
                logic [BLOCK_WIDTH:0] k;
                assign k[0] = c[0];
                for (j = 0; j < BLOCK_WIDTH; j++) begin : g_fa
                    assign k[j+1] = g[j] | (p[j] & k[j]);
                end
                assign sum[i*BLOCK_WIDTH +: BLOCK_WIDTH] = p ^ k[BLOCK_WIDTH-1:0];
                assign c[i+1] = k[BLOCK_WIDTH];
            end else begin : g_hi
                // both carry-in cases ripple in parallel; the real block carry only drives the muxes
                logic [BLOCK_WIDTH:0] k0, k1;
                assign k0[0] = 1'b0;
                assign k1[0] = 1'b1;
                for (j = 0; j < BLOCK_WIDTH; j++) begin : g_fa
                    assign k0[j+1] = g[j] | (p[j] & k0[j]);
                    assign k1[j+1] = g[j] | (p[j] & k1[j]);
                end
                assign sum[i*BLOCK_WIDTH +: BLOCK_WIDTH] = c[i] ? p ^ k1[BLOCK_WIDTH-1:0] : p ^ k0[BLOCK_WIDTH-1:0];
                assign c[i+1] = c[i] ? k1[BLOCK_WIDTH] : k0[BLOCK_WIDTH];
            end
        end
    endgenerate
    always_comb begin
        s_d    = sum;
        cout_d = c[NB];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end
    assign s    = s_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_csa_32.sv
// tb_csa_32: scoreboard bench driving four csa_32 instances (BLOCK_WIDTH 2/4/8/16) with shared stimulus
module tb_csa_32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic [31:0] s2, s4, s8, s16;
    logic        c2, c4, c8, c16;
    logic [32:0] got [4];
    int          bw [4] = '{2, 4, 8, 16};
    logic [32:0] exp_q [$];
    int          tests = 0, failed = 0;

    always #5 clk = ~clk;

    csa_32 #(.BLOCK_WIDTH(2))  u2  (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .s(s2),  .cout(c2));
    csa_32 #(.BLOCK_WIDTH(4))  u4  (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .s(s4),  .cout(c4));
    csa_32 #(.BLOCK_WIDTH(8))  u8  (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .s(s8),  .cout(c8));
    csa_32 #(.BLOCK_WIDTH(16)) u16 (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .s(s16), .cout(c16));

    assign got[0] = {c2, s2};
    assign got[1] = {c4, s4};
    assign got[2] = {c8, s8};
    assign got[3] = {c16, s16};

    // drive on the falling edge, record the reference sum, then sample just after the capture edge
    task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic ci);
        @(negedge clk);
        a = x;
        b = y;
        cin = ci;
        exp_q.push_back({1'b0, x} + {1'b0, y} + {32'b0, ci});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [32:0] e;
        rst = 1'b1;
        a = 32'd5;
        b = 32'd7;
        cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got[k] !== 33'h0) begin
                failed++;
                $display("FAIL reset_hold bw=%0d got=%h exp=%h", bw[k], got[k], 33'h0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        apply(32'd5, 32'd7, 1'b1);
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got[k] !== e) begin
                failed++;
                $display("FAIL reset_first_capture bw=%0d got=%h exp=%h", bw[k], got[k], e);
            end
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [10] = '{32'd0, 32'd0, 32'd4, 32'd33456865, 32'd42356436, 32'd22142132,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000F, 32'h000000FF};
        logic [31:0] vb [10] = '{32'd0, 32'd1, 32'd8, 32'd255664433, 32'd56754564, 32'd7454565,
                                 32'hFFFFFFFF, 32'd0, 32'd1, 32'h00000001};
        logic        vc [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [32:0] e;
        for (int v = 0; v < 10; v++) begin
            apply(va[v], vb[v], vc[v]);
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (got[k] !== e) begin
                    failed++;
                    $display("FAIL vector%0d bw=%0d got=%h exp=%h", v, bw[k], got[k], e);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [32:0] e;
        apply(32'h12345678, 32'h0F0F0F0F, 1'b1);
        e = exp_q.pop_front();
        a = 32'hDEADBEEF;
        b = 32'hCAFEF00D;
        cin = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got[k] !== e) begin
                failed++;
                $display("FAIL hold_between_edges bw=%0d got=%h exp=%h", bw[k], got[k], e);
            end
        end
    endtask

    task automatic test_random();
        logic [32:0] e;
        for (int v = 0; v < 10000; v++) begin
            apply($urandom, $urandom, 1'($urandom_range(0, 1)));
            e = exp_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (got[k] !== e) begin
                    failed++;
                    $display("FAIL random%0d bw=%0d got=%h exp=%h", v, bw[k], got[k], e);
                end
            end
            if (v % 2500 == 1234) begin
                rst = 1'b1;
                #1;
                for (int k = 0; k < 4; k++) begin
                    tests++;
                    if (got[k] !== 33'h0) begin
                        failed++;
                        $display("FAIL async_reset bw=%0d got=%h exp=%h", bw[k], got[k], 33'h0);
                    end
                end
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
